if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the ring-node CPU: owns the program counter, drives the synchronous instruction memory, and holds the IF/ID pipeline register that feeds `ID_inst` to the decode stage. It consumes decode's branch outputs (`ID_br_ctrl`, `ID_imm_addr`) and the hazard unit's stall. It redirects on taken branches with a one-cycle bubble and replays the in-flight fetch during stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `PC_STEP`, default 4, sequential PC increment in bytes.
- `clk`  in  1  single clock; all flops are rising-edge.
- `reset`  in  1  asynchronous, active-low reset. Low forces every flop to its reset value immediately; deassertion is synchronous to the design.
- `HDU_stall`  in  1  freeze request from the hazard unit.
- `ID_br_ctrl`  in  1  branch taken, from decode (combinational in decode).
- `ID_imm_addr`  in  [0:15]  absolute branch target.
- `imem_inst`  in  [0:31]  read data for the address issued in the previous cycle.
- `imem_addr`  out  [0:31]  fetch address (combinational).
- `imem_rdEn`  out  1  read enable, equal to `reset` (high whenever out of reset).
- `ID_inst`  out  [0:31]  IF/ID instruction register.
- `ID_inst_vld`  out  1  `ID_inst` is a real instruction, not a bubble.
- `ID_pc`  out  [0:31]  byte address of `ID_inst`.

## Operation
- **Registers and reset values:**
  - `pc` = RESET_PC
  - `issued_addr` = RESET_PC
  - `fetch_vld` = 0
  - `ID_inst` = NOP_INST (32'hF000_0000)
  - `ID_inst_vld` = 0
  - `ID_pc` = 0
- **FSM via `fetch_vld`:** FILL (0, no read in flight) → RUN (1) on the first non-stalled cycle. It stays in RUN until reset.
- **Branch taken** is `br_take = ID_br_ctrl & ID_inst_vld & ~HDU_stall`.
- **Target:** `target = {16'b0, ID_imm_addr}`.
- **Per-cycle priority:**
  1. **Stall** (`HDU_stall` = 1):
     - `imem_addr` = `issued_addr` (replay the in-flight read).
     - `pc`, `issued_addr`, `fetch_vld`, `ID_inst`, `ID_inst_vld` and `ID_pc` all hold.
     - `ID_br_ctrl` is ignored.
  2. **Branch** (`br_take`):
     - `imem_addr` = `target`.
     - `pc` ← `target + PC_STEP`; `issued_addr` ← `target`.
     - `ID_inst` ← NOP_INST; `ID_inst_vld` ← 0. This squashes the wrong-path `imem_inst`.
  3. **Sequential:**
     - `imem_addr` = `pc`.
     - `pc` ← `pc + PC_STEP`; `issued_addr` ← `pc`; `fetch_vld` ← 1.
     - If `fetch_vld` = 1: `ID_inst` ← `imem_inst`, `ID_inst_vld` ← 1, `ID_pc` ← `issued_addr`.
     - Otherwise: `ID_inst` ← NOP_INST, `ID_inst_vld` ← 0.
- **Arithmetic:** all PC arithmetic is unsigned 32-bit and wraps modulo 2^32, with no overflow flag.
- **Bubbles:** `ID_pc` holds its previous value during bubbles; only `ID_inst_vld` distinguishes them.

## Timing
- **Latency:** address issue to `ID_inst` visible at decode is 2 cycles (memory 1 cycle + IF/ID register 1 cycle).
- **After reset release**, counting the first edge as edge 0:
  - Cycle 0: `imem_addr` = RESET_PC.
  - Cycle 1: `ID_inst` = NOP and `imem_addr` = RESET_PC+4.
  - Cycle 2: `ID_inst` = instruction at RESET_PC.
- **Branch penalty:** exactly one bubble. The target is fetched in the same cycle `br_take` is high, so the target instruction reaches ID two cycles later.
- **Stall:** N stall cycles freeze ID for N cycles. The first non-stalled cycle latches the replayed `imem_inst`. No instruction is lost or duplicated.
- **Stall during FILL:** the block stays in FILL and no read is counted.
- **Reset asserted mid-run:**
  - All registered outputs take their reset values asynchronously within the cycle.
  - `imem_rdEn` drops to 0.
  - Fetch restarts at RESET_PC.

## Structure
- **Shared `cpu_pkg`:** NOP_INST, INST_W = 32, ADDR_W = 32, IMM_W = 16. Decode's NOP detection uses the same NOP_INST.
- **Sub-module `pc_gen`:** next-address mux plus `pc`/`issued_addr`/`fetch_vld` registers. It outputs `imem_addr` and the current `issued_addr`.
- **Top level:** holds the IF/ID register and the squash/hold control.

## Test plan
- **Reset and sequential fetch.** Stimulus: memory model returns `inst = addr ^ 32'hA5A5_0000`; release reset. Required: `imem_addr` 0, 4, 8, …; `ID_inst` NOP/vld 0 at cycle 1; at cycle 2, `ID_inst` = 32'hA5A5_0000 with `ID_pc` = 0 and vld = 1.
- **Taken branch.** Stimulus: with `ID_pc` = 8, assert `ID_br_ctrl`, `ID_imm_addr` = 16'h0040. Required: same-cycle `imem_addr` = 0x40; next cycle `ID_inst` NOP/vld 0 and `imem_addr` = 0x44; the cycle after, `ID_pc` = 0x40 with vld = 1.
- **Stall.** Stimulus: `HDU_stall` = 1 for 3 cycles while `ID_pc` = 4. Required: `ID_inst`/`ID_pc` stable; `imem_addr` = 8 on all 3 cycles; the cycle after release, `ID_pc` = 8 and `imem_addr` = 0xC.
- **Stall and branch together.** Stimulus: `HDU_stall` = 1 and `ID_br_ctrl` = 1 in the same cycle. Required: `imem_addr` = `issued_addr` and no redirect. If the branch is re-presented unstalled, it is taken then.
- **Wrap-around.** Stimulus: RESET_PC = 32'hFFFF_FFF8. Required: `imem_addr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- **Reset mid-run.** Stimulus: drive `reset` low mid-cycle after 10 fetches. Required: `ID_inst` = NOP, `ID_inst_vld` = 0 and `imem_rdEn` = 0 before the next edge; after release, the fetch sequence restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the canonical NOP encoding and
// the fetch-state enumeration used by the instruction-fetch stage.
package cpu_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int IMM_W  = 16;

    // Decode recognises bubbles by this exact encoding.
    localparam logic [0:INST_W-1] NOP_INST = 32'hF000_0000;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: next-address mux plus the pc, issued-address
// and fill/run registers that track which address the memory is reading.
module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [0:ADDR_W-1] RESET_PC = 32'h0000_0000,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_take,
    input  logic [0:ADDR_W-1] target,
    output logic [0:ADDR_W-1] imem_addr,
    output logic [0:ADDR_W-1] issued_addr,
    output logic              fetch_vld
);
    localparam logic [0:ADDR_W-1] STEP = ADDR_W'(PC_STEP);

    logic [0:ADDR_W-1] pc_reg, pc_next;
    logic [0:ADDR_W-1] issued_reg, issued_next;
    fetch_state_t      state_reg, state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg     <= RESET_PC;
            issued_reg <= RESET_PC;
            state_reg  <= FILL;
        end else begin
            pc_reg     <= pc_next;
            issued_reg <= issued_next;
            state_reg  <= state_next;
        end
    end

    always_comb begin
        pc_next     = pc_reg;
        issued_next = issued_reg;
        state_next  = state_reg;
        imem_addr   = pc_reg;
        if (stall) begin
            // Re-issue the in-flight address so its data is still there on release.
            imem_addr = issued_reg;
        end else if (br_take) begin
            imem_addr   = target;
            pc_next     = target + STEP;
            issued_next = target;
        end else begin
            pc_next     = pc_reg + STEP;
            issued_next = pc_reg;
            state_next  = RUN;
        end
    end

    assign issued_addr = issued_reg;
    assign fetch_vld   = (state_reg == RUN);
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the synchronous instruction memory through
// pc_gen and holds the IF/ID register, squashing on taken branches.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [0:ADDR_W-1] RESET_PC = 32'h0000_0000,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HDU_stall,
    input  logic              ID_br_ctrl,
    input  logic [0:IMM_W-1]  ID_imm_addr,
    input  logic [0:INST_W-1] imem_inst,
    output logic [0:ADDR_W-1] imem_addr,
    output logic              imem_rdEn,
    output logic [0:INST_W-1] ID_inst,
    output logic              ID_inst_vld,
    output logic [0:ADDR_W-1] ID_pc
);
    logic [0:INST_W-1] id_inst_reg, id_inst_next;
    logic              id_vld_reg, id_vld_next;
    logic [0:ADDR_W-1] id_pc_reg, id_pc_next;
    logic [0:ADDR_W-1] issued_addr;
    logic [0:ADDR_W-1] target;
    logic              fetch_vld;
    logic              br_take;

    // Only a real instruction in ID may redirect; a stall defers the decision.
    assign br_take = ID_br_ctrl & id_vld_reg & ~HDU_stall;
    assign target  = {{(ADDR_W-IMM_W){1'b0}}, ID_imm_addr};

    pc_gen #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk         (clk),
        .reset       (reset),
        .stall       (HDU_stall),
        .br_take     (br_take),
        .target      (target),
        .imem_addr   (imem_addr),
        .issued_addr (issued_addr),
        .fetch_vld   (fetch_vld)
    );

    always_comb begin
        id_inst_next = id_inst_reg;
        id_vld_next  = id_vld_reg;
        id_pc_next   = id_pc_reg;
        if (!HDU_stall) begin
            if (br_take || !fetch_vld) begin
                id_inst_next = NOP_INST;
                id_vld_next  = 1'b0;
            end else begin
                id_inst_next = imem_inst;
                id_vld_next  = 1'b1;
                id_pc_next   = issued_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_inst_reg <= NOP_INST;
            id_vld_reg  <= 1'b0;
            id_pc_reg   <= '0;
        end else begin
            id_inst_reg <= id_inst_next;
            id_vld_reg  <= id_vld_next;
            id_pc_reg   <= id_pc_next;
        end
    end

    assign imem_rdEn   = reset;
    assign ID_inst     = id_inst_reg;
    assign ID_inst_vld = id_vld_reg;
    assign ID_pc       = id_pc_reg;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/branch/stall/reset scenarios followed by
// random stall/branch traffic, all checked against a transaction-level model.
module tb_if_stage;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'hF000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] imm = '0;
    logic [31:0] mem_q = '0;
    logic [31:0] imem_addr, id_inst, id_pc;
    logic        rd_en, id_vld;

    logic [31:0] w_addr, w_inst, w_pc;
    logic        w_rd_en, w_vld;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Reference state: next sequential address, address whose data is in flight,
    // whether a read is in flight, and the expected IF/ID contents.
    logic [31:0] m_pc, m_iss, m_inst, m_idpc, w_m;
    logic        m_run, m_vld;
    logic [31:0] last_addr, last_w_addr;

    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .HDU_stall   (stall),
        .ID_br_ctrl  (br),
        .ID_imm_addr (imm),
        .imem_inst   (mem_q),
        .imem_addr   (imem_addr),
        .imem_rdEn   (rd_en),
        .ID_inst     (id_inst),
        .ID_inst_vld (id_vld),
        .ID_pc       (id_pc)
    );

    if_stage #(.RESET_PC(WRAP_PC), .PC_STEP(4)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .HDU_stall   (1'b0),
        .ID_br_ctrl  (1'b0),
        .ID_imm_addr (16'h0000),
        .imem_inst   (32'h0000_0000),
        .imem_addr   (w_addr),
        .imem_rdEn   (w_rd_en),
        .ID_inst     (w_inst),
        .ID_inst_vld (w_vld),
        .ID_pc       (w_pc)
    );

    // Synchronous instruction memory: contents are address ^ KEY.
    always @(posedge clk) begin
        if (rd_en) mem_q <= imem_addr ^ KEY;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_iss = 32'h0; m_run = 1'b0;
        m_inst = NOP; m_vld = 1'b0; m_idpc = 32'h0;
        w_m = WRAP_PC;
    endtask

    // One clock: drive inputs, check the combinational address, clock, check ID.
    task automatic step(input logic s, input logic b, input logic [15:0] i);
        logic [31:0] exp_addr, tgt;
        logic        take;
        stall = s; br = b; imm = i;
        #1;
        tgt  = {16'h0, i};
        take = b && m_vld && !s;
        if (s)         exp_addr = m_iss;
        else if (take) exp_addr = tgt;
        else           exp_addr = m_pc;
        last_addr   = imem_addr;
        last_w_addr = w_addr;
        check_eq("imem_addr", imem_addr, exp_addr);
        check_eq("rd_en", {31'h0, rd_en}, 32'h1);
        check_eq("wrap_addr", w_addr, w_m);
        if (!s) begin
            if (take) begin
                m_inst = NOP; m_vld = 1'b0;
                m_iss = tgt; m_pc = tgt + 32'd4;
            end else begin
                if (m_run) begin
                    m_inst = m_iss ^ KEY; m_vld = 1'b1; m_idpc = m_iss;
                end else begin
                    m_inst = NOP; m_vld = 1'b0;
                end
                m_iss = m_pc; m_pc = m_pc + 32'd4; m_run = 1'b1;
            end
        end
        w_m = w_m + 32'd4;
        @(posedge clk);
        #1;
        cyc++;
        check_eq("id_inst", id_inst, m_inst);
        check_eq("id_vld", {31'h0, id_vld}, {31'h0, m_vld});
        check_eq("id_pc", id_pc, m_idpc);
        $display("[TB] cyc %0d stall=%0b br=%0b imm=%h addr=%h id_inst=%h id_pc=%h vld=%0b",
                 cyc, s, b, i, last_addr, id_inst, id_pc, id_vld);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_inst"}, id_inst, NOP);
        check_eq({tag, "_vld"}, {31'h0, id_vld}, 32'h0);
        check_eq({tag, "_pc"}, id_pc, 32'h0);
        check_eq({tag, "_rden"}, {31'h0, rd_en}, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        check_eq("rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Sequential fetch from reset, plus the wrapping instance.
        step(1'b0, 1'b0, 16'h0);
        check_eq("c0_addr", last_addr, 32'h0);
        check_eq("c1_nop", id_inst, NOP);
        check_eq("wrap0", last_w_addr, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 16'h0);
        check_eq("c1_addr", last_addr, 32'h4);
        check_eq("c2_inst", id_inst, 32'hA5A5_0000);
        check_eq("c2_vld", {31'h0, id_vld}, 32'h1);
        check_eq("wrap1", last_w_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 16'h0);
        check_eq("c2_addr", last_addr, 32'h8);
        check_eq("wrap2", last_w_addr, 32'h0000_0000);

        // Stall for three cycles with ID_pc = 4.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 16'h0);
            check_eq("stall_addr", last_addr, 32'h8);
            check_eq("stall_idpc", id_pc, 32'h4);
            if (k == 0) check_eq("wrap3", last_w_addr, 32'h0000_0004);
        end
        step(1'b0, 1'b0, 16'h0);
        check_eq("unstall_addr", last_addr, 32'hC);
        check_eq("unstall_idpc", id_pc, 32'h8);
        check_eq("unstall_inst", id_inst, 32'h8 ^ KEY);

        // Taken branch at ID_pc = 8.
        step(1'b0, 1'b1, 16'h0040);
        check_eq("br_addr", last_addr, 32'h40);
        check_eq("br_bubble", {31'h0, id_vld}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        check_eq("br_next_addr", last_addr, 32'h44);
        check_eq("br_tgt_pc", id_pc, 32'h40);
        check_eq("br_tgt_vld", {31'h0, id_vld}, 32'h1);

        // Stall and branch together: no redirect until re-presented unstalled.
        step(1'b1, 1'b1, 16'h0100);
        check_eq("sb_addr", last_addr, 32'h44);
        check_eq("sb_idpc", id_pc, 32'h40);
        step(1'b0, 1'b1, 16'h0100);
        check_eq("sb_taken", last_addr, 32'h100);
        step(1'b0, 1'b0, 16'h0);
        check_eq("sb_tgt_pc", id_pc, 32'h100);

        // Random stall/branch traffic.
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 16'hFFFF)));

        // Ten clean fetches, then reset mid-cycle.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 16'h0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 16'h0);
        check_eq("restart_addr", last_addr, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        check_eq("restart_addr1", last_addr, 32'h4);

        for (int k = 0; k < 100; k++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 16'hFFFF)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
